mux4x1_rr_arbiter: RTL

- Sequential controller that shares one 4:1 selection datapath among four requesters using round-robin arbitration.
- Drives the 2-bit select and a one-hot grant, and registers the selected lane into a single output stage.
- Limits how long one requester can hold the grant (MAX_HOLD beats), which bounds starvation.
- Sits in front of the 4x1 mux structure and replaces a static select with fair, handshaked scheduling.

---
 rtl/mux4x1_rr_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mux4x1_rr_arbiter.sv
// rtl/mux4x1_rr_arbiter.sv - round-robin arbitrated 4:1 mux with hold limit and registered output stage (optional ARB_LOCK_EN)
`timescale 1ns/1ps
module mux4x1_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  input  logic               out_ready,
`ifdef ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Beat index that ends a grant: the MAX_HOLD-th accepted beat.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         last_q, last_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;

  logic               beat;
  logic               rel_grant;
  logic               hold_done;
  logic               lock_active;
  logic [1:0]         pick_idle;
  logic [1:0]         pick_rel;
  logic [WIDTH-1:0]   lane_sel;

`ifdef ARB_LOCK_EN
  assign lock_active = lock;
`else
  assign lock_active = 1'b0;
`endif

  // First asserted request in the order last+1, last+2, last+3, last (mod 4).
  // The previous owner is checked last so it only wins when it is alone.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // 4:1 data mux steered by the registered select.
  always_comb begin
    lane_sel = din[WIDTH-1:0];
    case (sel_q)
      2'd0: lane_sel = din[0*WIDTH +: WIDTH];
      2'd1: lane_sel = din[1*WIDTH +: WIDTH];
      2'd2: lane_sel = din[2*WIDTH +: WIDTH];
      2'd3: lane_sel = din[3*WIDTH +: WIDTH];
      default: lane_sel = din[WIDTH-1:0];
    endcase
  end

  // Candidate winners: from the current pointer (IDLE) and from the owner
  // being released, so a release re-arbitrates without an idle bubble.
  always_comb begin
    pick_idle = rr_pick(req, last_q);
    pick_rel  = rr_pick(req, sel_q);
  end

  // Next-state logic: arbitration, beat acceptance, hold counting and release.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    hold_cnt_d  = hold_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    beat        = 1'b0;
    hold_done   = 1'b0;
    rel_grant   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != 4'b0000) begin
          state_d    = ST_GRANT;
          gnt_d      = 4'b0001 << pick_idle;
          sel_d      = pick_idle;
          hold_cnt_d = 8'd0;
        end
      end

      ST_GRANT: begin
        beat = req[sel_q] && out_ready;
        // >= keeps the limit effective if lock let the count run past it.
        hold_done = beat && (hold_cnt_q >= HOLD_LAST) && !lock_active;
        rel_grant = !req[sel_q] || hold_done;

        if (beat) begin
          out_valid_d = 1'b1;
          out_data_d  = lane_sel;
          if (hold_cnt_q != 8'hFF) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end

        if (rel_grant) begin
          last_d     = sel_q;
          hold_cnt_d = 8'd0;
          if (req != 4'b0000) begin
            gnt_d = 4'b0001 << pick_rel;
            sel_d = pick_rel;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 4'b0000;
      sel_q       <= 2'd0;
      last_q      <= 2'd3;
      hold_cnt_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == ST_GRANT);

endmodule
